// File: rtl/player_mover.sv
// Grid-based player controller: decodes arrow-key make codes into a small
// command queue, checks each target cell against obstacle memory, and redraws the player.
module player_mover #(
    parameter int X_W        = 8,
    parameter int Y_W        = 7,
    parameter int X_MAX      = 159,
    parameter int Y_MAX      = 119,
    parameter int INIT_X     = 134,
    parameter int INIT_Y     = 119,
    parameter int STEP_TICKS = 2_500_000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic [7:0]     keycode,
    input  logic           key_valid,
    input  logic           key_make,
    input  logic           key_ext,
    output logic [X_W-1:0] obs_x,
    output logic [Y_W-1:0] obs_y,
    input  logic [2:0]     obs_mem,
    input  logic           draw_busy,
    output logic           plot,
    output logic [X_W-1:0] draw_x,
    output logic [Y_W-1:0] draw_y,
    output logic [2:0]     color_draw,
    output logic [X_W-1:0] xpos,
    output logic [Y_W-1:0] ypos,
    output logic           fifo_full,
    output logic           busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_DECIDE, S_ERASE, S_DRAW, S_SLIDE
    } state_e;

    typedef enum logic [1:0] {D_LEFT, D_RIGHT, D_UP, D_DOWN} dir_e;

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int TICK_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_TICKS - 1);

    localparam logic [2:0] C_WALL   = 3'b000;
    localparam logic [2:0] C_ICE    = 3'b001;
    localparam logic [2:0] C_LAVA   = 3'b100;
    localparam logic [2:0] C_TRAIL  = 3'b101;
    localparam logic [2:0] C_PLAYER = 3'b010;

    // ---------------- key decode ----------------
    logic cmd_valid;
    dir_e cmd_dir;

    always_comb begin
        cmd_valid = 1'b0;
        cmd_dir   = D_LEFT;
        if (key_valid && key_make && key_ext) begin
            case (keycode)
                8'h6B: begin cmd_valid = 1'b1; cmd_dir = D_LEFT;  end
                8'h74: begin cmd_valid = 1'b1; cmd_dir = D_RIGHT; end
                8'h75: begin cmd_valid = 1'b1; cmd_dir = D_UP;    end
                8'h72: begin cmd_valid = 1'b1; cmd_dir = D_DOWN;  end
                default: ;
            endcase
        end
    end

    // ---------------- command FIFO ----------------
    logic [1:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push, pop, fifo_empty;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign push       = cmd_valid && !fifo_full;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    // NOTE: storage needs no reset; only the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= cmd_dir;
    end

    // ---------------- movement FSM ----------------
    state_e             state_q, state_d;
    dir_e               dir_q, dir_d;
    logic [X_W-1:0]     xpos_q, xpos_d, nx_q, nx_d, obs_x_q, obs_x_d;
    logic [Y_W-1:0]     ypos_q, ypos_d, ny_q, ny_d, obs_y_q, obs_y_d;
    logic               slide_q, slide_d;
    logic [TICK_W-1:0]  tick_q, tick_d;

    // One step from the current position, flagged invalid at the playfield edge.
    logic [X_W-1:0] tgt_x;
    logic [Y_W-1:0] tgt_y;
    logic           tgt_ok;

    always_comb begin
        tgt_x  = xpos_q;
        tgt_y  = ypos_q;
        tgt_ok = 1'b1;
        case (dir_q)
            D_LEFT:  if (xpos_q == '0) tgt_ok = 1'b0; else tgt_x = xpos_q - 1'b1;
            D_RIGHT: if (xpos_q >= X_W'(X_MAX)) tgt_ok = 1'b0; else tgt_x = xpos_q + 1'b1;
            D_UP:    if (ypos_q == '0) tgt_ok = 1'b0; else tgt_y = ypos_q - 1'b1;
            default: if (ypos_q >= Y_W'(Y_MAX)) tgt_ok = 1'b0; else tgt_y = ypos_q + 1'b1;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        nx_d       = nx_q;
        ny_d       = ny_q;
        slide_d    = slide_q;
        tick_d     = tick_q;
        xpos_d     = xpos_q;
        ypos_d     = ypos_q;
        obs_x_d    = obs_x_q;
        obs_y_d    = obs_y_q;
        pop        = 1'b0;
        plot       = 1'b0;
        draw_x     = '0;
        draw_y     = '0;
        color_draw = '0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    dir_d   = dir_e'(fifo_mem[rd_ptr_q]);
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (tgt_ok) begin
                    obs_x_d = tgt_x;
                    obs_y_d = tgt_y;
                    state_d = S_WAIT;
                end else begin
                    slide_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_WAIT: state_d = S_DECIDE;
            S_DECIDE: begin
                // obs_x_q/obs_y_q still hold the target cell fetched two cycles ago.
                slide_d = (obs_mem == C_ICE);
                if (obs_mem == C_WALL) begin
                    state_d = S_IDLE;
                end else begin
                    if (obs_mem == C_LAVA) begin
                        nx_d = X_W'(INIT_X);
                        ny_d = Y_W'(INIT_Y);
                    end else begin
                        nx_d = obs_x_q;
                        ny_d = obs_y_q;
                    end
                    state_d = S_ERASE;
                end
            end
            S_ERASE: begin
                if (!draw_busy) begin
                    plot       = 1'b1;
                    draw_x     = xpos_q;
                    draw_y     = ypos_q;
                    color_draw = C_TRAIL;
                    state_d    = S_DRAW;
                end
            end
            S_DRAW: begin
                if (!draw_busy) begin
                    plot       = 1'b1;
                    draw_x     = nx_q;
                    draw_y     = ny_q;
                    color_draw = C_PLAYER;
                    xpos_d     = nx_q;
                    ypos_d     = ny_q;
                    state_d    = slide_q ? S_SLIDE : S_IDLE;
                end
            end
            S_SLIDE: begin
                if (tick_q == TICK_LAST) begin
                    tick_d  = '0;
                    state_d = S_FETCH;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            dir_q    <= D_LEFT;
            nx_q     <= X_W'(INIT_X);
            ny_q     <= Y_W'(INIT_Y);
            slide_q  <= 1'b0;
            tick_q   <= '0;
            xpos_q   <= X_W'(INIT_X);
            ypos_q   <= Y_W'(INIT_Y);
            obs_x_q  <= X_W'(INIT_X);
            obs_y_q  <= Y_W'(INIT_Y);
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            nx_q     <= nx_d;
            ny_q     <= ny_d;
            slide_q  <= slide_d;
            tick_q   <= tick_d;
            xpos_q   <= xpos_d;
            ypos_q   <= ypos_d;
            obs_x_q  <= obs_x_d;
            obs_y_q  <= obs_y_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign obs_x = obs_x_q;
    assign obs_y = obs_y_q;
    assign xpos  = xpos_q;
    assign ypos  = ypos_q;
    assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_player_mover.sv
// Scoreboard bench for player_mover: a behavioural grid model predicts every
// plot when a key is sent; a monitor pops and compares each plot the DUT makes.
module tb_player_mover;

    localparam int INIT_X = 134;
    localparam int INIT_Y = 119;
    localparam int STEP   = 4;
    localparam int L = 0, R = 1, U = 2, D = 3;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] keycode;
    logic       key_valid, key_make, key_ext;
    logic [7:0] obs_x;
    logic [6:0] obs_y;
    logic [2:0] obs_mem;
    logic       draw_busy;
    logic       plot;
    logic [7:0] draw_x, xpos;
    logic [6:0] draw_y, ypos;
    logic [2:0] color_draw;
    logic       fifo_full, busy;

    player_mover #(
        .X_W(8), .Y_W(7), .X_MAX(159), .Y_MAX(119),
        .INIT_X(INIT_X), .INIT_Y(INIT_Y), .STEP_TICKS(STEP), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .resetn(resetn), .keycode(keycode), .key_valid(key_valid),
        .key_make(key_make), .key_ext(key_ext), .obs_x(obs_x), .obs_y(obs_y),
        .obs_mem(obs_mem), .draw_busy(draw_busy), .plot(plot), .draw_x(draw_x),
        .draw_y(draw_y), .color_draw(color_draw), .xpos(xpos), .ypos(ypos),
        .fifo_full(fifo_full), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [2:0] map [0:159][0:119];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [31:0] exp_q[$];
    int plot_cyc[$];
    int mx, my;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [2:0] c, input logic [7:0] x, input logic [6:0] y);
        return {14'd0, c, x, y};
    endfunction

    // Obstacle memory: synchronous read, data valid one cycle after the address.
    always @(posedge clk) begin
        if (obs_x < 8'd160 && obs_y < 7'd120) obs_mem <= map[obs_x][obs_y];
        else obs_mem <= 3'bxxx;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (resetn && plot) begin
            plot_cyc.push_back(cyc);
            check("plot_while_busy", 32'(draw_busy), 0);
            if (exp_q.size() == 0) check("unexpected_plot", 32'(plot), 0);
            else check("plot_pixel", pack(color_draw, draw_x, draw_y), exp_q.pop_front());
        end
    end

    // Predicts the plots of one command, following slides until they stop.
    function automatic void model_move(input int d);
        int tx, ty;
        logic [2:0] c;
        for (int s = 0; s < 200; s++) begin
            tx = mx;
            ty = my;
            if ((d == L && mx == 0) || (d == R && mx == 159) ||
                (d == U && my == 0) || (d == D && my == 119)) break;
            case (d)
                L:       tx = mx - 1;
                R:       tx = mx + 1;
                U:       ty = my - 1;
                default: ty = my + 1;
            endcase
            c = map[tx][ty];
            if (c == 3'b000) break;
            exp_q.push_back(pack(3'b101, mx[7:0], my[6:0]));
            if (c == 3'b100) begin
                tx = INIT_X;
                ty = INIT_Y;
            end
            exp_q.push_back(pack(3'b010, tx[7:0], ty[6:0]));
            mx = tx;
            my = ty;
            if (c != 3'b001) break;
        end
    endfunction

    function automatic logic [7:0] code_of(input int d);
        case (d)
            L:       return 8'h6B;
            R:       return 8'h74;
            U:       return 8'h75;
            default: return 8'h72;
        endcase
    endfunction

    task automatic send_key(input logic [7:0] code, input logic mk, input logic ex);
        @(posedge clk); #1;
        keycode = code; key_make = mk; key_ext = ex; key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic cmd(input int d, input bit will_run);
        if (will_run) model_move(d);
        send_key(code_of(d), 1'b1, 1'b1);
    endtask

    task automatic set_busy(input logic b);
        @(posedge clk); #1;
        draw_busy = b;
    endtask

    // Waits until the FSM has been idle for three straight cycles, then
    // requires every predicted plot to have appeared.
    task automatic wait_idle();
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < 3000) begin
            @(negedge clk);
            n++;
            quiet = busy ? 0 : quiet + 1;
        end
        if (quiet < 3) check("idle_timeout", 32'(busy), 0);
        check("sb_drained", exp_q.size(), 0);
    endtask

    initial begin
        for (int x = 0; x < 160; x++)
            for (int y = 0; y < 120; y++)
                map[x][y] = 3'b010;
        map[135][118] = 3'b000;
        map[134][119] = 3'b001;
        map[133][119] = 3'b001;
        map[132][119] = 3'b001;
        map[39][50]   = 3'b100;

        resetn = 1'b0; keycode = 8'h00; key_valid = 1'b0;
        key_make = 1'b0; key_ext = 1'b0; draw_busy = 1'b0;
        mx = INIT_X; my = INIT_Y;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("rst_xpos", xpos, INIT_X);
        check("rst_ypos", ypos, INIT_Y);
        check("rst_obs_x", obs_x, INIT_X);
        check("rst_obs_y", obs_y, INIT_Y);
        check("rst_plot", plot, 0);
        check("rst_busy", busy, 0);
        check("rst_full", fifo_full, 0);
        check("rst_draw", pack(color_draw, draw_x, draw_y), 0);

        // DOWN at the bottom edge: no read, no plot, no move.
        cmd(D, 1'b1);
        wait_idle();
        check("edge_obs_x", obs_x, INIT_X);
        check("edge_obs_y", obs_y, INIT_Y);
        check("edge_ypos", ypos, INIT_Y);

        // Break codes, non-extended codes and unknown codes are ignored.
        send_key(8'h74, 1'b0, 1'b1);
        send_key(8'h74, 1'b1, 1'b0);
        send_key(8'h1C, 1'b1, 1'b1);
        wait_idle();
        check("ignored_xpos", xpos, INIT_X);

        // RIGHT onto floor.
        cmd(R, 1'b1);
        wait_idle();
        check("right_xpos", xpos, 135);
        check("right_ypos", ypos, 119);
        check("right_obs_hold_x", obs_x, 135);
        check("right_obs_hold_y", obs_y, 119);

        // UP into a wall.
        cmd(U, 1'b1);
        wait_idle();
        check("wall_xpos", xpos, 135);
        check("wall_ypos", ypos, 119);
        check("wall_busy", busy, 0);

        // LEFT over three ice cells onto floor: four moves.
        plot_cyc.delete();
        cmd(L, 1'b1);
        wait_idle();
        check("ice_xpos", xpos, 131);
        check("ice_plots", plot_cyc.size(), 8);
        for (int i = 3; i < 8 && i < plot_cyc.size(); i += 2)
            check("ice_gap_ok", 32'((plot_cyc[i] - plot_cyc[i-2]) >= STEP + 5), 1);

        // Six commands while stalled: four queue, two drop.
        set_busy(1'b1);
        cmd(U, 1'b1);
        repeat (8) @(posedge clk);
        cmd(L, 1'b1);
        cmd(U, 1'b1);
        cmd(U, 1'b1);
        cmd(L, 1'b1);
        @(negedge clk);
        check("fifo_full_4", fifo_full, 1);
        cmd(D, 1'b0);
        cmd(R, 1'b0);
        @(negedge clk);
        check("fifo_full_6", fifo_full, 1);
        check("stall_busy", busy, 1);
        check("stall_plot", plot, 0);
        set_busy(1'b0);
        wait_idle();
        check("fifo_xpos", xpos, 129);
        check("fifo_ypos", ypos, 116);
        check("fifo_empty", fifo_full, 0);

        // Walk to (40,50).
        for (int i = 0; i < 89; i++) begin cmd(L, 1'b1); wait_idle(); end
        for (int i = 0; i < 66; i++) begin cmd(U, 1'b1); wait_idle(); end
        check("walk_xpos", xpos, 40);
        check("walk_ypos", ypos, 50);

        // Lava with draw_busy stalls before each plot.
        plot_cyc.delete();
        set_busy(1'b1);
        cmd(L, 1'b1);
        repeat (8) @(posedge clk);
        #1 draw_busy = 1'b0;
        @(posedge clk); #1 draw_busy = 1'b1;
        repeat (10) @(posedge clk);
        #1 draw_busy = 1'b0;
        wait_idle();
        check("lava_xpos", xpos, INIT_X);
        check("lava_ypos", ypos, INIT_Y);
        check("lava_plots", plot_cyc.size(), 2);
        if (plot_cyc.size() == 2)
            check("lava_gap_ok", 32'((plot_cyc[1] - plot_cyc[0]) >= 11), 1);

        // Reset in the middle of a slide with commands queued.
        cmd(L, 1'b1);
        cmd(R, 1'b0);
        cmd(U, 1'b0);
        begin
            int n = 0;
            while (xpos != 8'd132 && n < 300) begin
                @(negedge clk);
                n++;
            end
        end
        check("slide_reached", xpos, 132);
        #1 resetn = 1'b0;
        exp_q.delete();
        mx = INIT_X; my = INIT_Y;
        @(negedge clk);
        check("midrst_xpos", xpos, INIT_X);
        check("midrst_busy", busy, 0);
        @(posedge clk); #1 resetn = 1'b1;
        @(negedge clk);
        check("release_plot", plot, 0);
        check("release_busy", busy, 0);
        repeat (30) @(negedge clk);
        check("after_rst_xpos", xpos, INIT_X);
        check("after_rst_ypos", ypos, INIT_Y);
        check("after_rst_busy", busy, 0);
        check("after_rst_full", fifo_full, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/player_mover.md
PLAYER_MOVER -- requirements
Module: player_mover

Interface
REQ-001 Parameters (name, default, meaning):
  X_W, 8, x-coordinate width; Y_W, 7, y-coordinate width
  X_MAX, 159, largest legal x; Y_MAX, 119, largest legal y
  INIT_X, 134, spawn x; INIT_Y, 119, spawn y
  STEP_TICKS, 2_500_000, cycles between ice-slide steps (>=1)
  FIFO_DEPTH, 4, queued move commands (power of 2, >=2)
REQ-002 Ports (name, direction, width, meaning):
  clk  in  1  system clock
  resetn  in  1  asynchronous active-low reset
  keycode  in  8  PS/2 scan code
  key_valid  in  1  one-cycle strobe qualifying keycode/key_make/key_ext
  key_make  in  1  1=make, 0=break
  key_ext  in  1  extended (E0) code
  obs_x  out  X_W  obstacle-memory read x address
  obs_y  out  Y_W  obstacle-memory read y address
  obs_mem  in  3  colour at (obs_x,obs_y), valid exactly 1 cycle after address
  draw_busy  in  1  VGA writer cannot accept a plot
  plot  out  1  one-cycle pixel write strobe
  draw_x  out  X_W / draw_y  out  Y_W / color_draw  out  3  pixel to write
  xpos  out  X_W / ypos  out  Y_W  current player position
  fifo_full  out  1  command queue full
  busy  out  1  FSM not in IDLE

Function
REQ-003 Command decode: on key_valid with key_make=1, key_ext=1: keycode 0x6B=LEFT, 0x74=RIGHT, 0x75=UP, 0x72=DOWN; all other events ignored.
REQ-004 Decoded commands enter a FIFO_DEPTH-entry FIFO; push when full drops the command; fifo_full=1 when count==FIFO_DEPTH.
REQ-005 Simultaneous push and pop in one cycle both occur; count unchanged.
REQ-006 FSM states: IDLE, FETCH, WAIT, DECIDE, ERASE, DRAW, SLIDE.
REQ-007 IDLE: if FIFO non-empty, pop into register dir, go FETCH; else stay.
REQ-008 FETCH: target = position + one step in dir; if target outside [0,X_MAX]x[0,Y_MAX] (including x=0 LEFT, y=0 UP, no wrap), go IDLE with no move; else drive obs_x/obs_y=target, go WAIT.
REQ-009 WAIT: one cycle; DECIDE samples obs_mem.
REQ-010 DECIDE: obs_mem 000 (wall) -> IDLE, no move; 100 (lava) -> new position = (INIT_X,INIT_Y); any other -> new position = target; latch slide=1 iff obs_mem==001 (ice) else 0; go ERASE.
REQ-011 ERASE: when draw_busy=0, plot=1 for one cycle at old position, color 101 (purple trail); go DRAW.
REQ-012 DRAW: when draw_busy=0, update xpos/ypos to new position and plot=1 at it, color 010 (green); go SLIDE if slide=1, else IDLE.
REQ-013 plot never asserts while draw_busy=1; ERASE/DRAW hold with plot=0 until draw_busy=0.
REQ-014 SLIDE: count STEP_TICKS cycles, then go FETCH with dir unchanged; FIFO not popped while sliding; slide ends when blocked (wall or bound) or landing on non-ice.
REQ-015 obs_x/obs_y hold last driven address outside FETCH/WAIT.
REQ-016 busy=1 in every state except IDLE.

Reset
REQ-017 resetn=0 asynchronously: state=IDLE, xpos=INIT_X, ypos=INIT_Y, FIFO empty, tick counter=0, slide=0, plot=0, obs_x=INIT_X, obs_y=INIT_Y, draw_x/draw_y=0, color_draw=000.
REQ-018 Reset mid-move or mid-slide discards in-flight command and queued commands; no plot in the cycle after release.

Verification
REQ-019 RIGHT make at (134,119), obs_mem=010 -> plot purple (134,119), then plot green (135,119); xpos=135.
REQ-020 UP, obs_mem=000 -> no plot, position unchanged, FSM returns to IDLE.
REQ-021 DOWN at y=119 (Y_MAX) -> no memory read, no plot, position unchanged.
REQ-022 STEP_TICKS=4, LEFT onto three ice cells then floor -> four moves, successive moves 4+ cycles apart, ending at x-4.
REQ-023 Six commands pushed back-to-back while busy, FIFO_DEPTH=4 -> fifo_full=1, exactly four executed in order.
REQ-024 Lava target from (40,50) -> plot purple (40,50), plot green (134,119); draw_busy held 10 cycles delays each plot, each plot one cycle wide.
